// File: rtl/useq_port_fifo_if.sv
// rtl/useq_port_fifo_if.sv - port FIFO handshake/status bundle
//
// Groups the write side, read side, status flags and interrupt request of
// one useq port FIFO instance.
//   master : producer/consumer side (drives wr_*, rd_en, clr_err, irq_en)
//   slave  : the FIFO itself (drives rd_data, count, flags, irq)
// DATA_W and DEPTH must match the parameters of the attached FIFO.
interface useq_port_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              clr_err;
    logic              irq_en;
    logic              irq;

    modport master (
        output wr_en, wr_data, rd_en, clr_err, irq_en,
        input  rd_data, empty, full, count, almost_full, almost_empty,
               overflow, underflow, irq
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err, irq_en,
        output rd_data, empty, full, count, almost_full, almost_empty,
               overflow, underflow, irq
    );
endinterface

// File: rtl/useq_port_fifo.sv
// rtl/useq_port_fifo.sv - parametrised first-word-fall-through port FIFO
//
// Ports:
//   clk    : single clock, all state changes on its rising edge
//   rst_n  : synchronous active-low reset
//   bus    : useq_port_fifo_if.slave
//            wr_en/wr_data push, rd_en pops the head (rd_data shows head),
//            empty/full/count/almost_* occupancy status,
//            overflow/underflow sticky errors cleared by clr_err,
//            irq registered request gated by irq_en.
module useq_port_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int AE_LEVEL  = 1,
    parameter int IRQ_LEVEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    useq_port_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [AW:0]       count_q;
    logic [AW:0]       count_next;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_new;
    logic              unf_new;
    logic              ovf_q;
    logic              unf_q;
    logic              irq_q;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (AW+1)'(DEPTH));

    always_comb begin
        // A write into a full FIFO still lands when a pop frees the head slot
        // in the same cycle; the pointers never collide because rp moves too.
        wr_acc     = bus.wr_en && (!is_full || bus.rd_en);
        rd_acc     = bus.rd_en && !is_empty;
        ovf_new    = bus.wr_en && is_full && !bus.rd_en;
        unf_new    = bus.rd_en && is_empty;
        count_next = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    end

    // Storage is deliberately not reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp <= wp + AW'(1);
            end
            if (rd_acc) begin
                rp <= rp + AW'(1);
            end
            count_q <= count_next;
            // New errors win over a simultaneous clear.
            ovf_q   <= (ovf_q && !bus.clr_err) || ovf_new;
            unf_q   <= (unf_q && !bus.clr_err) || unf_new;
            irq_q   <= bus.irq_en && (count_next >= (AW+1)'(IRQ_LEVEL));
        end
    end

    assign bus.rd_data      = mem[rp];
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= (AW+1)'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= (AW+1)'(AE_LEVEL));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
    assign bus.irq          = irq_q;
endmodule

// File: doc/useq_port_fifo.md
# useq_port_fifo

Parametrised port FIFO for the `useq` micro-sequencer family. It generalises the fixed 8-bit, fixed-depth I/O FIFO into a block with configurable width, depth and thresholds. It adds sticky overflow/underflow error flags and a level-triggered interrupt request that feeds the sequencer's ISR vector logic. It sits between the sequencer's `o_port`/`i_port` datapath and an external producer or consumer, one instance per direction.

## Interface
- `DATA_W`, default 8: data width in bits (≥1).
- `DEPTH`, default 4: number of entries; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `AF_LEVEL`, default `DEPTH-1`: `almost_full` asserts when `count ≥ AF_LEVEL`.
- `AE_LEVEL`, default 1: `almost_empty` asserts when `count ≤ AE_LEVEL`.
- `IRQ_LEVEL`, default 1: `irq` requests service when `count ≥ IRQ_LEVEL`; range 1..DEPTH.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  pop the head entry this cycle.
- `rd_data`  out  DATA_W  head entry, first-word-fall-through; valid while `empty`=0.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  threshold flag, see `AF_LEVEL`.
- `almost_empty`  out  1  threshold flag, see `AE_LEVEL`.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a read was issued while empty.
- `clr_err`  in  1  clears `overflow` and `underflow`.
- `irq_en`  in  1  interrupt enable.
- `irq`  out  1  registered interrupt request.

## Operation
- Storage is a register array of DEPTH×DATA_W. It uses write pointer `wp` and read pointer `rp`, each AW bits. Pointers wrap modulo DEPTH through natural overflow. `count` is a separate AW+1-bit register.
- Write accepted: `wr_en` and (`!full` or `rd_en`). On acceptance, `mem[wp] <= wr_data` and `wp` advances.
- Read accepted: `rd_en` and `!empty`. On acceptance, `rp` advances. `rd_data = mem[rp]`, decoded combinationally from registers.
- `count_next = count + wr_acc - rd_acc`.
- Full with `wr_en` and `rd_en`: both are accepted, `count` stays DEPTH, and there is no overflow.
- Full with `wr_en` only: the write is dropped, `overflow` is set to 1, and memory and pointers are unchanged.
- Empty with `rd_en`: no pop and `underflow` is set to 1. If `wr_en` is also high, the write is accepted and `count` becomes 1. There is no bypass, so `rd_data` is not consumed that cycle.
- Sticky flags: next value = (flag & !clr_err) | new_error. A new error in the same cycle as `clr_err` leaves the flag set.
- `irq <= irq_en & (count_next ≥ IRQ_LEVEL)`. It deasserts on the edge at which occupancy falls below `IRQ_LEVEL` or `irq_en` goes low.
- `empty`, `full`, `almost_full` and `almost_empty` are decoded combinationally from the registered `count`.

## Timing
- Reset (`rst_n`=0 at a rising edge): `wp`=`rp`=0, `count`=0, `overflow`=`underflow`=0, `irq`=0. After reset, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0.
- `rd_data` is don't-care while `empty`. Memory contents are not reset.
- Reset mid-operation discards all contents; the flags above apply from the following cycle.
- Write latency: a write at edge N makes `empty`=0, `count`=1 and `rd_data`=written word visible immediately after edge N.
- Read latency: a pop at edge N presents the next entry on `rd_data` immediately after edge N.
- Throughput: one write and one read per cycle, sustained, at any occupancy.
- `irq` and all flags change only on rising edges of `clk`; there are no combinational input-to-output paths.

## Test plan
- Reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles (DEPTH=4) -> `count` 1,2,3,4; `full`=1 after the 4th; `almost_full`=1 at count 3; `rd_data`=0x11 throughout.
- From full, write 0x55 alone -> `overflow`=1, `count`=4. Then read 4 -> 0x11, 0x22, 0x33, 0x44 in order; `empty`=1 at the end.
- From full, simultaneous write 0x66 and read -> pops 0x11, `count`=4, `overflow` unchanged. Ten more simultaneous ops, read back and verify order across pointer wrap.
- Read while empty with `wr_en`=1, data 0x77 -> `underflow`=1, `count`=1, `rd_data`=0x77. Pulse `clr_err` with no error -> flags clear. Pulse `clr_err` together with a new overflow -> `overflow` stays 1.
- `irq_en`=1, IRQ_LEVEL=2: write 1 -> `irq`=0; write 2nd -> `irq`=1 after that edge; read 1 -> `irq`=0 after that edge. `irq_en`=0 with count 4 -> `irq`=0.
- Assert `rst_n`=0 for one cycle at count 3 with `overflow`=1 -> all outputs return to their reset values. A subsequent write of 0xA5 reads back 0xA5.
